// File: rtl/inst_encode_pkg.sv
// encode_pkg: shared types and constants for the RV32I instruction encoder.
//   enc_op_t     - request operation codes (codes not listed are illegal)
//   enc_state_t  - encoder FSM states (LI_LO exists only with INST_ENCODE_LI_EN)
//   OP_* / F3_* / F7_* - RV32I opcode, funct3 and funct7 fields
//   NOP_INST     - ADDI x0,x0,0, substituted for illegal requests
//   fits_s12 / pack_i - 12-bit signed range check and I-type packer
// Configuration macro: INST_ENCODE_LI_EN (enables the LI pseudo-op).
package encode_pkg;

   typedef enum logic [3:0] {
      ENC_LUI   = 4'd0,
      ENC_AUIPC = 4'd1,
      ENC_ADDI  = 4'd2,
      ENC_ADD   = 4'd3,
      ENC_SUB   = 4'd4,
      ENC_AND   = 4'd5,
      ENC_OR    = 4'd6,
      ENC_XOR   = 4'd7,
      ENC_JAL   = 4'd8,
      ENC_LI    = 4'd9
   } enc_op_t;

`ifdef INST_ENCODE_LI_EN
   typedef enum logic {IDLE = 1'b0, LI_LO = 1'b1} enc_state_t;
`else
   typedef enum logic {IDLE = 1'b0} enc_state_t;
`endif

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   // True when v, read as signed, lies in -2048..2047.
   function automatic logic fits_s12(input logic [31:0] v);
      return (v[31:11] == '0) || (v[31:11] == '1);
   endfunction

   // ADDI rd,rs1,imm12
   function automatic logic [31:0] pack_i(input logic [11:0] imm12,
                                          input logic [4:0]  rs1,
                                          input logic [4:0]  rd);
      return {imm12, rs1, F3_ADD, rd, OP_IMM};
   endfunction

endpackage

// File: rtl/inst_encode_if.sv
// inst_encode_if: request and result channels of the encoder.
//   in_*  : request (valid/ready), op, rd/rs1/rs2, imm
//   out_* : result word (valid/ready), inst, err
// Handshake: a beat transfers on a rising edge where valid && ready. A source
// holds valid and its payload stable until the transfer; a sink may change
// ready at any time, and ready never depends on valid.
// modport slave is the encoder, modport master is whoever drives requests
// and consumes words.
interface inst_encode_if;
   import encode_pkg::*;

   logic        in_valid;
   logic        in_ready;
   enc_op_t     in_op;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [31:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic        out_err;

   modport master (
      output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
      input  in_ready, out_valid, out_inst, out_err
   );

   modport slave (
      input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
      output in_ready, out_valid, out_inst, out_err
   );
endinterface

// File: rtl/inst_encode_fmt.sv
// inst_fmt: combinational format packing and immediate legality checks.
//   op/rd/rs1/rs2/imm : request fields
//   inst / err        : primary word (NOP_INST when err=1)
//   two_word / lo_inst: LI needs a second ADDI word (INST_ENCODE_LI_EN only)
// Register fields a format does not use never reach the word.
module inst_fmt
   import encode_pkg::*;
(
   input  enc_op_t     op,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
`ifdef INST_ENCODE_LI_EN
   output logic        two_word,
   output logic [31:0] lo_inst,
`endif
   output logic [31:0] inst,
   output logic        err
);

`ifdef INST_ENCODE_LI_EN
   // (imm + 0x800) >> 12: the low 12 bits carry out exactly when imm[11]=1,
   // which pre-compensates the sign extension of the trailing ADDI.
   logic [19:0] li_hi;
   assign li_hi = imm[31:12] + {19'd0, imm[11]};
`endif

   always_comb begin
      inst = NOP_INST;
      err  = 1'b0;
`ifdef INST_ENCODE_LI_EN
      two_word = 1'b0;
      lo_inst  = NOP_INST;
`endif
      case (op)
         ENC_LUI, ENC_AUIPC: begin
            if (imm[11:0] != 12'd0) err = 1'b1;
            else inst = {imm[31:12], rd, (op == ENC_LUI) ? OP_LUI : OP_AUIPC};
         end
         ENC_ADDI: begin
            if (!fits_s12(imm)) err = 1'b1;
            else inst = pack_i(imm[11:0], rs1, rd);
         end
         ENC_ADD: inst = {F7_BASE, rs2, rs1, F3_ADD, rd, OP_REG};
         ENC_SUB: inst = {F7_SUB,  rs2, rs1, F3_ADD, rd, OP_REG};
         ENC_AND: inst = {F7_BASE, rs2, rs1, F3_AND, rd, OP_REG};
         ENC_OR:  inst = {F7_BASE, rs2, rs1, F3_OR,  rd, OP_REG};
         ENC_XOR: inst = {F7_BASE, rs2, rs1, F3_XOR, rd, OP_REG};
         ENC_JAL: begin
            // Legal offsets are even and fit a 21-bit signed field.
            if (imm[0] || !((imm[31:20] == '0) || (imm[31:20] == '1))) err = 1'b1;
            else inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
         end
`ifdef INST_ENCODE_LI_EN
         ENC_LI: begin
            if (fits_s12(imm)) begin
               inst = pack_i(imm[11:0], 5'd0, rd);
            end else begin
               inst     = {li_hi, rd, OP_LUI};
               two_word = 1'b1;
               lo_inst  = pack_i(imm[11:0], rd, rd);
            end
         end
`endif
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/inst_encode.sv
// inst_encode: registered RV32I instruction encoder.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : inst_encode_if.slave (request in, encoded word out)
//   dbg_state  : current FSM state
// Latency 1; one word per cycle when the consumer keeps out_ready high.
// Configuration macro: INST_ENCODE_LI_EN builds the LI pseudo-op, whose large
// immediates expand to LUI then ADDI (state LI_LO holds the ADDI word).
module inst_encode
   import encode_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   inst_encode_if.slave  bus,
   output enc_state_t    dbg_state
);

   enc_state_t  state, state_nxt;
   logic        out_valid_q, out_err_q;
   logic [31:0] out_inst_q;
   logic        accept, out_take;
   logic [31:0] fmt_inst;
   logic        fmt_err;
`ifdef INST_ENCODE_LI_EN
   logic        fmt_two;
   logic [31:0] fmt_lo, lo_q;
`endif

   inst_fmt u_fmt (
      .op       (bus.in_op),
      .rd       (bus.in_rd),
      .rs1      (bus.in_rs1),
      .rs2      (bus.in_rs2),
      .imm      (bus.in_imm),
`ifdef INST_ENCODE_LI_EN
      .two_word (fmt_two),
      .lo_inst  (fmt_lo),
`endif
      .inst     (fmt_inst),
      .err      (fmt_err)
   );

   assign bus.in_ready  = (state == IDLE) && (!out_valid_q || bus.out_ready);
   assign accept        = bus.in_valid && bus.in_ready;
   assign out_take      = out_valid_q && bus.out_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_inst  = out_inst_q;
   assign bus.out_err   = out_err_q;
   assign dbg_state     = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
`ifdef INST_ENCODE_LI_EN
      case (state)
         IDLE:    if (accept && fmt_two) state_nxt = LI_LO;
         LI_LO:   if (out_take)          state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
`else
      state_nxt = IDLE;
`endif
   end

   // Output register. A reset in LI_LO also drops the pending ADDI: lo_q is
   // cleared and the state returns to IDLE, so it can never be emitted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_inst_q  <= '0;
         out_err_q   <= 1'b0;
`ifdef INST_ENCODE_LI_EN
         lo_q        <= '0;
`endif
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_inst_q  <= fmt_inst;
         out_err_q   <= fmt_err;
`ifdef INST_ENCODE_LI_EN
         if (fmt_two) lo_q <= fmt_lo;
      end else if ((state == LI_LO) && out_take) begin
         // LUI word leaves this edge; the ADDI word replaces it with no gap.
         out_valid_q <= 1'b1;
         out_inst_q  <= lo_q;
         out_err_q   <= 1'b0;
`endif
      end else if (out_take) begin
         out_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_inst_encode.sv
// tb_inst_encode: table-driven bench for inst_encode with an expected-word
// queue; works with and without INST_ENCODE_LI_EN.
module tb_inst_encode;
  import encode_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  enc_state_t dbg_state;
  int         n_tests = 0;
  int         n_fail = 0;
  int         n_words = 0;
  int         cycle = 0;

  inst_encode_if bus();

  inst_encode dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    enc_op_t     op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] w0;
    logic        e0;
    logic        two;
    logic [31:0] w1;
    string       name;
  } vec_t;

  logic [32:0] exp_q[$];   // {err, inst}
  string       name_q[$];

  function automatic vec_t mk(input enc_op_t op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input logic [31:0] w0,
                              input logic e0, input logic two,
                              input logic [31:0] w1, input string name);
    vec_t v;
    v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.w0 = w0; v.e0 = e0; v.two = two; v.w1 = w1; v.name = name;
    return v;
  endfunction

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every word the consumer takes is compared against the queue.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_words++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_word: got %h with no word expected", {bus.out_err, bus.out_inst});
      end else begin
        chk(name_q.pop_front(), {bus.out_err, bus.out_inst}, exp_q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the request transfers.
  task automatic send(input vec_t v);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op = v.op; bus.in_rd = v.rd; bus.in_rs1 = v.rs1;
    bus.in_rs2 = v.rs2; bus.in_imm = v.imm;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back({v.e0, v.w0});
        name_q.push_back(v.name);
        if (v.two) begin
          exp_q.push_back({1'b0, v.w1});
          name_q.push_back({v.name, "_lo"});
        end
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout_%s: got in_ready=0 for 50 cycles expected acceptance", v.name);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 33'(exp_q.size()), 33'd0);
  endtask

  vec_t        b2b[$];
  vec_t        tbl[$];
  vec_t        li_big, li_small, a_vec, b_vec;
  logic        gap_ready;
  int          t0, w0;

  initial begin
    bus.in_valid = 1'b0; bus.in_op = ENC_ADD; bus.in_rd = '0;
    bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_imm = '0; bus.out_ready = 1'b1;

    b2b.push_back(mk(ENC_LUI,  5'd1, 5'd0, 5'd0, 32'h0002_3000, 32'h0002_30B7, 1'b0, 1'b0, 32'h0, "lui"));
    b2b.push_back(mk(ENC_ADDI, 5'd2, 5'd1, 5'd0, 32'h0000_0054, 32'h0540_8113, 1'b0, 1'b0, 32'h0, "addi"));
    b2b.push_back(mk(ENC_ADD,  5'd3, 5'd2, 5'd1, 32'h0,         32'h0011_01B3, 1'b0, 1'b0, 32'h0, "add"));
    b2b.push_back(mk(ENC_SUB,  5'd4, 5'd2, 5'd1, 32'h0,         32'h4011_0233, 1'b0, 1'b0, 32'h0, "sub"));

    tbl.push_back(mk(ENC_AND,   5'd6,  5'd7,  5'd8,  32'h0,         32'h0083_F333, 1'b0, 1'b0, 32'h0, "and"));
    tbl.push_back(mk(ENC_OR,    5'd9,  5'd10, 5'd11, 32'h0,         32'h00B5_64B3, 1'b0, 1'b0, 32'h0, "or"));
    tbl.push_back(mk(ENC_XOR,   5'd1,  5'd2,  5'd3,  32'hDEAD_BEEF, 32'h0031_40B3, 1'b0, 1'b0, 32'h0, "xor_imm_ignored"));
    tbl.push_back(mk(ENC_AUIPC, 5'd10, 5'd31, 5'd31, 32'hFFFF_F000, 32'hFFFF_F517, 1'b0, 1'b0, 32'h0, "auipc_regs_ignored"));
    tbl.push_back(mk(ENC_ADDI,  5'd1,  5'd0,  5'd0,  32'hFFFF_F800, 32'h8000_0093, 1'b0, 1'b0, 32'h0, "addi_min"));
    tbl.push_back(mk(ENC_ADDI,  5'd1,  5'd1,  5'd0,  32'h0000_07FF, 32'h7FF0_8093, 1'b0, 1'b0, 32'h0, "addi_max"));
    tbl.push_back(mk(ENC_ADDI,  5'd1,  5'd1,  5'd0,  32'h0000_0800, NOP_INST,      1'b1, 1'b0, 32'h0, "addi_over"));
    tbl.push_back(mk(ENC_ADD,   5'd3,  5'd2,  5'd1,  32'h0,         32'h0011_01B3, 1'b0, 1'b0, 32'h0, "add_after_err"));
    tbl.push_back(mk(ENC_JAL,   5'd1,  5'd0,  5'd0,  32'h0000_0008, 32'h0080_00EF, 1'b0, 1'b0, 32'h0, "jal_fwd"));
    tbl.push_back(mk(ENC_JAL,   5'd0,  5'd0,  5'd0,  32'hFFFF_FFFC, 32'hFFDF_F06F, 1'b0, 1'b0, 32'h0, "jal_back"));
    tbl.push_back(mk(ENC_JAL,   5'd0,  5'd0,  5'd0,  32'hFFF0_0000, 32'h8000_006F, 1'b0, 1'b0, 32'h0, "jal_min"));
    tbl.push_back(mk(ENC_JAL,   5'd1,  5'd0,  5'd0,  32'h0000_0003, NOP_INST,      1'b1, 1'b0, 32'h0, "jal_odd"));
    tbl.push_back(mk(ENC_JAL,   5'd1,  5'd0,  5'd0,  32'h0010_0000, NOP_INST,      1'b1, 1'b0, 32'h0, "jal_range"));
    tbl.push_back(mk(ENC_LUI,   5'd1,  5'd0,  5'd0,  32'h0002_3001, NOP_INST,      1'b1, 1'b0, 32'h0, "lui_low_bits"));
    tbl.push_back(mk(enc_op_t'(4'hF), 5'd1, 5'd1, 5'd1, 32'h0,      NOP_INST,      1'b1, 1'b0, 32'h0, "bad_op_f"));
    tbl.push_back(mk(enc_op_t'(4'hA), 5'd1, 5'd1, 5'd1, 32'h0,      NOP_INST,      1'b1, 1'b0, 32'h0, "bad_op_a"));

`ifdef INST_ENCODE_LI_EN
    li_big   = mk(ENC_LI, 5'd5, 5'd0, 5'd0, 32'h1234_5678, 32'h1234_52B7, 1'b0, 1'b1, 32'h6782_8293, "li_big");
    li_small = mk(ENC_LI, 5'd0, 5'd0, 5'd0, 32'hFFFF_F800, 32'h8000_0013, 1'b0, 1'b0, 32'h0, "li_small");
    gap_ready = 1'b0;
`else
    li_big   = mk(ENC_LI, 5'd5, 5'd0, 5'd0, 32'h1234_5678, NOP_INST, 1'b1, 1'b0, 32'h0, "li_big_off");
    li_small = mk(ENC_LI, 5'd0, 5'd0, 5'd0, 32'hFFFF_F800, NOP_INST, 1'b1, 1'b0, 32'h0, "li_small_off");
    gap_ready = 1'b1;
`endif
    tbl.push_back(li_small);

    // Reset values while held in reset, then ready right after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 33'(bus.out_valid), 33'd0);
    chk("rst_out_inst",  33'(bus.out_inst),  33'd0);
    chk("rst_out_err",   33'(bus.out_err),   33'd0);
    chk("rst_state",     33'(dbg_state),     33'(IDLE));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 33'(bus.in_ready), 33'd1);
    @(posedge clk); #1;

    // Back-to-back: four requests in four cycles.
    t0 = cycle;
    foreach (b2b[i]) send(b2b[i]);
    chk("b2b_cycles", 33'(cycle - t0), 33'd4);
    foreach (tbl[i]) send(tbl[i]);
    drain();

    // LI: in_ready must stay low while the ADDI half is pending.
    send(li_big);
    @(negedge clk);
    chk("li_gap_ready", 33'(bus.in_ready), 33'(gap_ready));
    @(posedge clk); #1;
    drain();

    // Backpressure: word A held 3 cycles, request B waits and is not lost.
    a_vec = mk(ENC_ADDI, 5'd7, 5'd7, 5'd0, 32'h0000_0001, 32'h0013_8393, 1'b0, 1'b0, 32'h0, "stall_a");
    b_vec = mk(ENC_OR,   5'd9, 5'd10, 5'd11, 32'h0,       32'h00B5_64B3, 1'b0, 1'b0, 32'h0, "stall_b");
    bus.out_ready = 1'b0;
    send(a_vec);
    fork
      send(b_vec);
      begin
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_in_ready",  33'(bus.in_ready),  33'd0);
          chk("stall_out_valid", 33'(bus.out_valid), 33'd1);
          chk("stall_out_inst",  33'(bus.out_inst),  33'(a_vec.w0));
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset while the first LI word is stalled: nothing may follow.
    bus.out_ready = 1'b0;
    send(li_big);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 33'(bus.out_valid), 33'd0);
    chk("midrst_state",     33'(dbg_state),     33'(IDLE));
    exp_q.delete();
    name_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    w0 = n_words;
    @(negedge clk);
    chk("midrst_ready", 33'(bus.in_ready), 33'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_word", 33'(n_words - w0), 33'd0);

    // Encoder still works after the aborted sequence.
    send(b2b[0]);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
